// File: rtl/motor_dir_pkg.sv
// rtl/motor_dir_pkg.sv - states, command encodings and output map for motor_dir_ctrl
// MOTOR_DIR_BRAKE_EN adds the BRAKE state and makes command 11 a brake instead of a coast.
package motor_dir_pkg;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_FWD,
    ST_REV,
    ST_DEAD
`ifdef MOTOR_DIR_BRAKE_EN
    , ST_BRAKE
`endif
  } state_t;

  localparam logic [1:0] CMD_FWD   = 2'b00;
  localparam logic [1:0] CMD_REV   = 2'b01;
  localparam logic [1:0] CMD_COAST = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  // Output pairs are {dir_out1, dir_out2}.
  localparam logic [1:0] OUT_STOP  = 2'b00;
  localparam logic [1:0] OUT_FWD   = 2'b10;
  localparam logic [1:0] OUT_REV   = 2'b01;
  localparam logic [1:0] OUT_DEAD  = 2'b00;
`ifdef MOTOR_DIR_BRAKE_EN
  localparam logic [1:0] OUT_BRAKE = 2'b11;
`endif

  function automatic logic cmd_is_coast(input logic [1:0] cmd);
    logic w_res;
`ifdef MOTOR_DIR_BRAKE_EN
    w_res = (cmd == CMD_COAST);
`else
    w_res = (cmd == CMD_COAST) || (cmd == CMD_BRAKE);
`endif
    return w_res;
  endfunction

  function automatic logic [1:0] out_map(input state_t s);
    logic [1:0] w_res;
    case (s)
      ST_FWD:   w_res = OUT_FWD;
      ST_REV:   w_res = OUT_REV;
      ST_DEAD:  w_res = OUT_DEAD;
`ifdef MOTOR_DIR_BRAKE_EN
      ST_BRAKE: w_res = OUT_BRAKE;
`endif
      default:  w_res = OUT_STOP;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/motor_dir_ctrl_if.sv
// rtl/motor_dir_ctrl_if.sv - command and bridge-drive bundle between a controller and motor_dir_ctrl
interface motor_dir_ctrl_if #(
  parameter int N_CH = 2
) ();

  logic [2*N_CH-1:0] dir_in;
  logic [N_CH-1:0]   dir_out1;
  logic [N_CH-1:0]   dir_out2;
  logic [N_CH-1:0]   busy;

  modport master (
    output dir_in,
    input  dir_out1,
    input  dir_out2,
    input  busy
  );

  modport slave (
    input  dir_in,
    output dir_out1,
    output dir_out2,
    output busy
  );

endinterface

// File: rtl/motor_dir_ch.sv
// rtl/motor_dir_ch.sv - one H-bridge channel: command register, direction FSM, dead-time counter
// BRAKE handling is present only when MOTOR_DIR_BRAKE_EN is defined.
module motor_dir_ch
  import motor_dir_pkg::*;
#(
  parameter int DEAD_CYC = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_cmd,
  output logic       o_out1,
  output logic       o_out2,
  output logic       o_busy
);

  localparam int            CW   = $clog2(DEAD_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(DEAD_CYC - 1);

  logic [1:0]    r_cmd_q;
  state_t        r_state;
  state_t        w_next;
  state_t        w_dir;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_out1;
  logic          r_out2;
  logic          r_busy;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_dir      = (r_cmd_q == CMD_REV) ? ST_REV : ST_FWD;
    if (cmd_is_coast(r_cmd_q)) begin
      w_next     = ST_STOP;
      w_cnt_next = '0;
    end
`ifdef MOTOR_DIR_BRAKE_EN
    else if (r_cmd_q == CMD_BRAKE) begin
      w_next     = ST_BRAKE;
      w_cnt_next = '0;
    end
`endif
    else begin
      case (r_state)
        // Dead time always runs to completion; exit follows the latest direction command.
        ST_DEAD: begin
          if (r_cnt == '0) w_next = w_dir;
          else             w_cnt_next = r_cnt - CW'(1);
        end
        ST_FWD, ST_REV: begin
          if (r_state != w_dir) begin
            w_next     = ST_DEAD;
            w_cnt_next = LOAD;
          end
        end
        default: w_next = w_dir;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_q <= CMD_COAST;
      r_state <= ST_STOP;
      r_cnt   <= '0;
      r_out1  <= 1'b0;
      r_out2  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cmd_q          <= i_cmd;
      r_state          <= w_next;
      r_cnt            <= w_cnt_next;
      {r_out1, r_out2} <= out_map(w_next);
      r_busy           <= (w_next == ST_DEAD);
    end
  end

  assign o_out1 = r_out1;
  assign o_out2 = r_out2;
  assign o_busy = r_busy;

endmodule

// File: rtl/motor_dir_ctrl.sv
// rtl/motor_dir_ctrl.sv - N_CH independent H-bridge direction controllers with reversal dead time
// Define MOTOR_DIR_BRAKE_EN to make command 11 an immediate brake.
module motor_dir_ctrl
  import motor_dir_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int DEAD_CYC = 1000
) (
  input logic              CLK,
  input logic              RST,
  motor_dir_ctrl_if.slave  bus
);

  logic [N_CH-1:0] w_out1;
  logic [N_CH-1:0] w_out2;
  logic [N_CH-1:0] w_busy;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    motor_dir_ch #(
      .DEAD_CYC (DEAD_CYC)
    ) u_ch (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_cmd  (bus.dir_in[2*c +: 2]),
      .o_out1 (w_out1[c]),
      .o_out2 (w_out2[c]),
      .o_busy (w_busy[c])
    );
  end

  assign bus.dir_out1 = w_out1;
  assign bus.dir_out2 = w_out2;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_motor_dir_ctrl.sv
// tb/tb_motor_dir_ctrl.sv - directed self-checking bench for motor_dir_ctrl (N_CH=2, DEAD_CYC=4)
module tb_motor_dir_ctrl;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_fail;

  motor_dir_ctrl_if #(.N_CH(2)) u_if ();

  motor_dir_ctrl #(
    .N_CH     (2),
    .DEAD_CYC (4)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Snapshot as {ch1 busy,out1,out2, ch0 busy,out1,out2}: STOP 000, FWD 010, REV 001, DEAD 100, BRAKE 011.
  function automatic logic [5:0] snap();
    return {u_if.busy[1], u_if.dir_out1[1], u_if.dir_out2[1],
            u_if.busy[0], u_if.dir_out1[0], u_if.dir_out2[0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    RST = 1'b1;
    u_if.dir_in = 4'b0000;
    tick();
    tick();
    exp = 6'b000_000;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL reset_hold: got %b want %b", snap(), exp); end
    RST = 1'b0;
    tick();
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL reset_edge1: got %b want %b", snap(), exp); end
    tick();
    exp = 6'b010_010;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL reset_edge2_fwd: got %b want %b", snap(), exp); end
  endtask

  task automatic test_reversal();
    logic [5:0] exp;
    u_if.dir_in = 4'b0001;
    tick();
    exp = 6'b010_010;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL rev_edge_k: got %b want %b", snap(), exp); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp = 6'b010_100;
      n_cmp++;
      if (snap() !== exp) begin n_fail++; $display("FAIL rev_dead_%0d: got %b want %b", i, snap(), exp); end
    end
    tick();
    exp = 6'b010_001;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL rev_exit: got %b want %b", snap(), exp); end
  endtask

  task automatic test_abort();
    logic [5:0] exp;
    u_if.dir_in = 4'b0000;
    tick();
    tick();
    exp = 6'b010_100;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL abort_enter_dead: got %b want %b", snap(), exp); end
    u_if.dir_in = 4'b0010;
    tick();
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL abort_edge1: got %b want %b", snap(), exp); end
    tick();
    exp = 6'b010_000;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL abort_stop: got %b want %b", snap(), exp); end
    u_if.dir_in = 4'b0000;
    tick();
    tick();
    exp = 6'b010_010;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL abort_refwd: got %b want %b", snap(), exp); end
    u_if.dir_in = 4'b0001;
    tick();
    tick();
    exp = 6'b010_100;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL flip_dead_1: got %b want %b", snap(), exp); end
    u_if.dir_in = 4'b0000;
    for (int i = 2; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin n_fail++; $display("FAIL flip_dead_%0d: got %b want %b", i, snap(), exp); end
    end
    tick();
    exp = 6'b010_010;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL flip_exit_fwd: got %b want %b", snap(), exp); end
  endtask

  task automatic test_brake();
    logic [5:0] exp;
    u_if.dir_in = 4'b1000;
    tick();
    tick();
    u_if.dir_in = 4'b0100;
    tick();
    tick();
    exp = 6'b001_010;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL brake_setup_rev: got %b want %b", snap(), exp); end
    u_if.dir_in = 4'b1100;
    tick();
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL brake_edge1: got %b want %b", snap(), exp); end
    tick();
`ifdef MOTOR_DIR_BRAKE_EN
    exp = 6'b011_010;
`else
    exp = 6'b000_010;
`endif
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL brake_cmd11: got %b want %b", snap(), exp); end
    u_if.dir_in = 4'b0000;
    tick();
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL brake_release_edge1: got %b want %b", snap(), exp); end
    tick();
    exp = 6'b010_010;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL brake_to_fwd: got %b want %b", snap(), exp); end
  endtask

  task automatic test_mid_dead_reset();
    logic [5:0] exp;
    u_if.dir_in = 4'b0001;
    tick();
    tick();
    tick();
    exp = 6'b010_100;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL mdr_in_dead: got %b want %b", snap(), exp); end
    RST = 1'b1;
    tick();
    exp = 6'b000_000;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL mdr_reset: got %b want %b", snap(), exp); end
    RST = 1'b0;
    tick();
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL mdr_release_edge1: got %b want %b", snap(), exp); end
    tick();
    exp = 6'b010_001;
    n_cmp++;
    if (snap() !== exp) begin n_fail++; $display("FAIL mdr_direct_rev: got %b want %b", snap(), exp); end
  endtask

  task automatic test_hold();
    logic [5:0] exp;
    exp = 6'b010_001;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin n_fail++; $display("FAIL hold_%0d: got %b want %b", i, snap(), exp); end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    RST    = 1'b1;
    u_if.dir_in = 4'b0000;
    test_reset();
    test_reversal();
    test_abort();
    test_brake();
    test_mid_dead_reset();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
